// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_BR_WAIT = 1'b1;

  typedef enum logic [0:0] {
    RUN     = ST_RUN,
    BR_WAIT = ST_BR_WAIT
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear; clear beats increment.
// Count updates one edge after inc/clr; never backpressures.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use/branch stalls, redirect flushes, dmem freezes.
// Controls are combinational from state and inputs; dmem_busy freezes everything, stats lag one edge.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             dmem_busy,
  input  logic             clr_stats,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             wait_timeout
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);

  hz_state_e       state, state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic            hz, load_use, br_alu, stall, redirect;

  assign hz = ex_reg_write && (ex_rd != REG_W'(REG_ZERO)) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign load_use = hz && ex_mem_read;
  assign br_alu   = hz && id_branch && !ex_mem_read;
  assign stall    = (state == BR_WAIT) || load_use || br_alu;
  // A stall swallows the branch decision; the branch re-resolves once operands are ready.
  assign redirect = id_jump || (id_branch && id_branch_taken);

  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mem_hold    = 1'b0;
    state_nxt   = state;
    if (!rst_n) begin
      state_nxt = RUN;
    end else if (dmem_busy) begin
      mem_hold = 1'b1;
    end else if (stall) begin
      id_ex_flush = 1'b1;
      if (state == BR_WAIT) state_nxt = RUN;
      else                  state_nxt = (load_use && id_branch) ? BR_WAIT : RUN;
    end else if (redirect) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
      state_nxt   = RUN;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      state_nxt   = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // wait_cnt parks at MAX_WAIT; the timeout latches on the edge that reaches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      wait_timeout <= 1'b0;
    end else if (clr_stats) begin
      wait_cnt     <= '0;
      wait_timeout <= 1'b0;
    end else if (dmem_busy) begin
      if (wait_cnt != WC_W'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == WC_W'(MAX_WAIT - 1)) wait_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (id_ex_flush),
    .clr   (clr_stats),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_id_flush),
    .clr   (clr_stats),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an expected-control scoreboard and a statistics model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rt, id_branch, id_branch_taken, id_jump;
  logic        ex_reg_write, ex_mem_read, dmem_busy, clr_stats;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, mem_hold;
  logic [15:0] stall_count, flush_count;
  logic        wait_timeout;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, mem_hold}
  localparam logic [4:0] C_ZERO   = 5'b00000;
  localparam logic [4:0] C_NORMAL = 5'b11000;
  localparam logic [4:0] C_STALL  = 5'b00010;
  localparam logic [4:0] C_REDIR  = 5'b11100;
  localparam logic [4:0] C_FREEZE = 5'b00001;

  logic [4:0] ctl;
  assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, mem_hold};

  logic [4:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int es = 0, ef = 0, wc = 0;
  logic et = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .CNT_W(16), .MAX_WAIT(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_branch       (id_branch),
    .id_branch_taken (id_branch_taken),
    .id_jump         (id_jump),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .dmem_busy       (dmem_busy),
    .clr_stats       (clr_stats),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_hold        (mem_hold),
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .wait_timeout    (wait_timeout)
  );

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic br, input logic tk, input logic jp,
                       input logic ew, input logic em, input logic [4:0] rd,
                       input logic busy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_branch = br; id_branch_taken = tk; id_jump = jp;
    ex_reg_write = ew; ex_mem_read = em; ex_rd = rd; dmem_busy = busy;
  endtask

  // Called at posedge+1 with inputs already driven; checks mid-cycle, returns at next posedge+1.
  task automatic step(input string tag, input logic [4:0] exp_ctl);
    logic [4:0] e;
    exp_q.push_back(exp_ctl);
    #3;
    e = exp_q.pop_front();
    checks++;
    assert (ctl === e) else begin
      errors++;
      $error("FAIL %s ctl got %b exp %b", tag, ctl, e);
    end
    checks++;
    assert (stall_count === 16'(es)) else begin
      errors++;
      $error("FAIL %s stall_count got %0d exp %0d", tag, stall_count, es);
    end
    checks++;
    assert (flush_count === 16'(ef)) else begin
      errors++;
      $error("FAIL %s flush_count got %0d exp %0d", tag, flush_count, ef);
    end
    checks++;
    assert (wait_timeout === et) else begin
      errors++;
      $error("FAIL %s wait_timeout got %b exp %b", tag, wait_timeout, et);
    end
    if (!rst_n || clr_stats) begin
      es = 0; ef = 0; wc = 0; et = 1'b0;
    end else begin
      if (e[1]) es++;
      if (e[2]) ef++;
      if (dmem_busy) begin
        wc++;
        if (wc == 8) et = 1'b1;
      end else begin
        wc = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_stats = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step("reset", C_ZERO);
    rst_n = 1'b1;
    step("idle", C_NORMAL);

    // load-use on rs: single bubble
    drive(2, 7, 0, 0, 0, 0, 1, 1, 2, 0);
    step("lu_stall", C_STALL);
    drive(2, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    step("lu_done", C_NORMAL);

    // load feeding a branch: two bubbles
    drive(3, 0, 1, 1, 0, 0, 1, 1, 3, 0);
    step("lbr_b1", C_STALL);
    drive(3, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step("lbr_b2", C_STALL);
    step("lbr_done", C_NORMAL);

    // ALU result feeding branch rt
    drive(0, 4, 1, 1, 0, 0, 1, 0, 4, 0);
    step("bralu_rt", C_STALL);
    drive(0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    step("bralu_r0", C_NORMAL);
    drive(0, 4, 0, 1, 0, 0, 1, 0, 4, 0);
    step("bralu_no_rt", C_NORMAL);
    drive(4, 0, 0, 0, 0, 0, 1, 0, 4, 0);
    step("alu_no_br", C_NORMAL);

    // redirects, and a taken branch that must wait for operands
    drive(1, 2, 1, 1, 1, 0, 0, 0, 0, 0);
    step("br_taken", C_REDIR);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("jump", C_REDIR);
    drive(5, 0, 0, 1, 1, 0, 1, 0, 5, 0);
    step("br_hz_taken", C_STALL);
    drive(5, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    step("br_resolve", C_REDIR);

    // dmem wait during a load-use stall
    drive(6, 0, 0, 0, 0, 0, 1, 1, 6, 1);
    for (int i = 0; i < 8; i++) step($sformatf("freeze%0d", i), C_FREEZE);
    drive(6, 0, 0, 0, 0, 0, 1, 1, 6, 0);
    step("freeze_resume", C_STALL);
    drive(6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("freeze_done", C_NORMAL);
    step("timeout_sticky", C_NORMAL);
    clr_stats = 1'b1;
    step("clr1", C_NORMAL);
    clr_stats = 1'b0;
    step("after_clr1", C_NORMAL);

    // reset while in BR_WAIT
    drive(3, 0, 0, 1, 0, 0, 1, 1, 3, 0);
    step("bw_enter", C_STALL);
    rst_n = 1'b0;
    es = 0; ef = 0; wc = 0; et = 1'b0;
    #1;
    checks++;
    assert (ctl === C_ZERO) else begin
      errors++;
      $error("FAIL rst_async ctl got %b exp %b", ctl, C_ZERO);
    end
    drive(3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    step("rst_bw", C_ZERO);
    rst_n = 1'b1;
    step("post_rst_run", C_NORMAL);

    // clear wins over a same-cycle increment
    drive(2, 0, 0, 0, 0, 0, 1, 1, 2, 0);
    step("pre_clr_stall", C_STALL);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("pre_clr_jump", C_REDIR);
    clr_stats = 1'b1;
    step("clr2_jump", C_REDIR);
    clr_stats = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_clr2", C_NORMAL);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
